tl_socket_1n: RTL
=================

# tl_socket_1n

Single-host, multi-device TileLink-C crossbar leaf. It fans out one upstream host link to `NumLinks` downstream device links. A and C messages are routed by address decode and E messages by sink-ID decode. D and B messages from the devices are arbitrated round-robin back onto the single host link, and multi-beat D bursts hold their grant until the last beat. The block sits between a cache/interconnect master and a set of memory-mapped slaves or cache controllers.

## Interface
- `SourceWidth`, 1: A/B/C/D source ID width.
- `SinkWidth`, 1: D/E sink ID width.
- `AddrWidth`, 56: address width.
- `DataWidth`, 64: beat data width.
- `MaxSize`, 6: log2 of the largest transfer in bytes; sets burst length.
- `NumLinks`, 1: number of device links. `LinkWidth = vbits(NumLinks)`.
- `NumCachedLinks`, `NumLinks`: links 0..N-1 carry B/C/E; higher links do not.
- `NumAddrRange`, 1: number of address table entries.
- `AddrBase`, `AddrMask`, `AddrLink`, all '0: address table. An address matches entry i when `(addr & ~AddrMask[i]) == AddrBase[i]`; the target is `AddrLink[i]`.
- `NumSinkRange`, 1: number of sink table entries.
- `SinkBase`, `SinkMask`, `SinkLink`, all '0: sink table, same match rule, applied to `e.sink`.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `host_{a,b,c,d,e}_{valid,ready}` and `host_{a,b,c,d,e}`, mixed direction, bundle: upstream device-side port, built with the shared device-port macro.
- `device_{a,b,c,d,e}_{valid,ready}` and `device_{a,b,c,d,e}`, mixed direction, `[NumLinks-1:0]` of bundle: downstream host-side port array, built with the shared host-port macro.

## Operation
- **A routing.** The target link is decoded from `host_a.address`. If no entry matches, the target is link 0. If several entries match, the highest index wins.
  - `device_a_valid[t] = host_a_valid`; all other links see valid 0.
  - `host_a_ready = device_a_ready[t]`.
  - All links receive the `host_a` payload.
  - A burst's address is constant, so no lock is needed.
- **C routing.** Same decode on `host_c.address`, restricted to cached links. A target of `NumCachedLinks` or above is a configuration error, and the message is sent to link 0.
- **E routing.** Decoded from `host_e.sink` using the sink table; default is link 0.
- **D arbitration.**
  - Round-robin arbiter over `device_d_valid`.
  - State: `gnt_locked` (reset 0) and `gnt_selected` (reset '0).
  - The arbiter pointer advances only on an unlocked handshake.
  - On a host D handshake while unlocked: set `gnt_locked` and latch the grant.
  - On the handshake of the last beat: clear `gnt_locked`. This takes priority, so a single-beat message never locks.
  - While locked, the select is `gnt_selected`; otherwise it is the live grant.
  - `device_d_ready[i] = select[i] & host_d_ready`.
- **B arbitration.** Round-robin over `device_b_valid[NumCachedLinks-1:0]`. B messages are single-beat, so there is no lock.
- **Non-cached links.**
  - `device_b_ready = 1`.
  - `device_c_valid = 0`, `device_e_valid = 0`, with payload don't-care.
- **`NumCachedLinks == 0`.**
  - `host_b_valid = 0`.
  - `host_c_ready = 1`, `host_e_ready = 1`.
- **Last-beat detection.** A `tl_burst_tracker` instance on the host port supplies `gnt_last`.
- **Reset mid-burst.** Reset clears the lock and the pointer immediately (asynchronously). No beats are retained.

## Timing
- Every path is zero-latency combinational. There are no valid→valid registers, and no throughput loss.
- Reset values:
  - All `*_valid` outputs are 0 because the upstream valids are 0. The block must not assert valid unprompted.
  - The arbiter pointer starts at link 0, so link 0 has highest priority first.
- Handshake rules:
  - No output valid depends on the corresponding ready.
  - A granted D source may not be switched while its burst is in flight, even if its valid drops between beats.
- If a locked D source drops valid, host D stalls until that source returns. Other sources are not granted.
- Simultaneous D requests from all links are served one message at a time, in strict rotation.

## Structure
- Address and sink decode functions are shared with the M:1 socket. Put them in `tl_pkg` as `tl_range_match(value, base, mask)`.
- Sub-modules: `openip_round_robin_arbiter` (×2, for B and D) and `tl_burst_tracker` (×1).

## Test plan
- **A routing.** Table {base 0x0000 → link 0, base 0x1000 with mask 0xFFF → link 1}. Send Get at 0x1040 → only `device_a_valid[1]` is asserted, and `host_a_ready` follows `device_a_ready[1]`. Send Get at 0x9000 → routed to link 0.
- **D burst lock.** Links 0 and 1 both present 64 B AccessAckData (8 beats of 64 bits). Link 0 is granted and streams all 8 beats uninterrupted, including when its valid gaps for 2 cycles → link 1 then gets 8 beats.
- **D round-robin.** With 3 links issuing continuous single-beat AccessAck, grant order is 0, 1, 2, 0, 1, 2.
- **B and E.** Cached link 1 issues ProbeBlock → it appears on host B. E with sink 3 and sink table {3 → link 1} → only `device_e_valid[1]` is asserted.
- **Non-cached link.** With `NumLinks=2`, `NumCachedLinks=1`: `device_b_ready[1]=1`, and `device_c_valid[1]` and `device_e_valid[1]` are never asserted.
- **Reset mid-burst.** Assert `rst_i` after beat 3 of 8 → the lock clears asynchronously. After release, a new request from link 1 is granted first-come, with no residual lock to link 0.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink helpers: opcode encodings, socket state types and the
// address/sink range decode used by both the 1:N and M:1 sockets.
package tl_pkg;

  localparam int TlMatchWidth = 64;

  typedef enum logic [2:0] {
    A_PUT_FULL      = 3'd0,
    A_PUT_PARTIAL   = 3'd1,
    A_ARITHMETIC    = 3'd2,
    A_LOGICAL       = 3'd3,
    A_GET           = 3'd4,
    A_INTENT        = 3'd5,
    A_ACQUIRE_BLOCK = 3'd6,
    A_ACQUIRE_PERM  = 3'd7
  } tl_a_op_e;

  typedef enum logic [2:0] {
    B_PROBE_BLOCK = 3'd6,
    B_PROBE_PERM  = 3'd7
  } tl_b_op_e;

  typedef enum logic [2:0] {
    C_PROBE_ACK      = 3'd4,
    C_PROBE_ACK_DATA = 3'd5,
    C_RELEASE        = 3'd6,
    C_RELEASE_DATA   = 3'd7
  } tl_c_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2,
    D_GRANT           = 3'd4,
    D_GRANT_DATA      = 3'd5,
    D_RELEASE_ACK     = 3'd6
  } tl_d_op_e;

  // D return-path grant state: open to the arbiter, or held for a burst.
  typedef enum logic {
    D_OPEN   = 1'b0,
    D_LOCKED = 1'b1
  } d_state_e;

  // Bits needed to index 'value' items; never less than one.
  function automatic int vbits(int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // A value hits a table entry when its unmasked bits equal the base.
  function automatic logic tl_range_match(logic [TlMatchWidth-1:0] value,
                                          logic [TlMatchWidth-1:0] base,
                                          logic [TlMatchWidth-1:0] mask);
    return (value & ~mask) == base;
  endfunction

endpackage

// File: rtl/openip_round_robin_arbiter.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves to one past the winner whenever the caller reports an accepted grant.
module openip_round_robin_arbiter
  import tl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PtrWidth = vbits(N);

  logic [PtrWidth-1:0] ptr;
  logic [PtrWidth-1:0] ptr_next;
  logic                found;

  // Search from the pointer upward, then wrap around from index 0.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    ptr_next = ptr;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i]   = 1'b1;
        found    = 1'b1;
        ptr_next = (i == N - 1) ? '0 : PtrWidth'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        gnt[i]   = 1'b1;
        found    = 1'b1;
        ptr_next = (i == N - 1) ? '0 : PtrWidth'(i + 1);
      end
    end
  end

  // Rotate priority only when the current grant was actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/tl_burst_tracker.sv
// Counts D beats on one link and flags the final beat of each message.
// Only AccessAckData and GrantData carry multiple beats.
module tl_burst_tracker
  import tl_pkg::*;
#(
  parameter int DataWidth = 64,
  parameter int MaxSize   = 6,
  parameter int SizeWidth = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 ready,
  input  logic [2:0]           opcode,
  input  logic [SizeWidth-1:0] size,
  output logic                 last
);

  localparam int BeatLog  = $clog2(DataWidth / 8);
  localparam int MaxBeats = (MaxSize > BeatLog) ? (1 << (MaxSize - BeatLog)) : 1;
  localparam int CntWidth = vbits(MaxBeats);

  logic [CntWidth-1:0] beats_left;
  logic [CntWidth-1:0] first_left;

  // Beats that follow the first one of the message now on the bus.
  always_comb begin
    first_left = '0;
    if (((opcode == D_ACCESS_ACK_DATA) || (opcode == D_GRANT_DATA)) &&
        (int'(size) > BeatLog)) begin
      first_left = CntWidth'((1 << (int'(size) - BeatLog)) - 1);
    end
    last = (beats_left == '0) ? (first_left == '0) : (beats_left == CntWidth'(1));
  end

  // Zero means "at a message boundary"; otherwise counts down to one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_left <= '0;
    end else if (valid && ready) begin
      beats_left <= (beats_left == '0) ? first_left : beats_left - CntWidth'(1);
    end
  end

endmodule

// File: rtl/tl_socket_1n.sv
// TileLink-C 1:N socket. A/C fan out by address, E by sink; D and B from the
// devices are merged round-robin, with D bursts holding their grant.
//
// D grant state | meaning
// D_OPEN        | select follows the live round-robin grant
// D_LOCKED      | select held on gnt_selected until the last beat
module tl_socket_1n
  import tl_pkg::*;
#(
  parameter int SourceWidth    = 1,
  parameter int SinkWidth      = 1,
  parameter int AddrWidth      = 56,
  parameter int DataWidth      = 64,
  parameter int MaxSize        = 6,
  parameter int NumLinks       = 1,
  parameter int NumCachedLinks = NumLinks,
  parameter int NumAddrRange   = 1,
  parameter int NumSinkRange   = 1,
  localparam int LinkWidth     = vbits(NumLinks),
  parameter logic [NumAddrRange-1:0][AddrWidth-1:0] AddrBase = '0,
  parameter logic [NumAddrRange-1:0][AddrWidth-1:0] AddrMask = '0,
  parameter logic [NumAddrRange-1:0][LinkWidth-1:0] AddrLink = '0,
  parameter logic [NumSinkRange-1:0][SinkWidth-1:0] SinkBase = '0,
  parameter logic [NumSinkRange-1:0][SinkWidth-1:0] SinkMask = '0,
  parameter logic [NumSinkRange-1:0][LinkWidth-1:0] SinkLink = '0,
  localparam int SizeWidth     = vbits(MaxSize + 1),
  localparam int MaskWidth     = DataWidth / 8,
  // A/B: {opcode, param, size, source, address, mask, corrupt, data}
  localparam int AWidth        = 6 + SizeWidth + SourceWidth + AddrWidth + MaskWidth + 1 + DataWidth,
  // C:   {opcode, param, size, source, address, corrupt, data}
  localparam int CWidth        = 6 + SizeWidth + SourceWidth + AddrWidth + 1 + DataWidth,
  // D:   {opcode, param[1:0], size, source, sink, denied, corrupt, data}
  localparam int DWidth        = 5 + SizeWidth + SourceWidth + SinkWidth + 2 + DataWidth,
  // E:   {sink}
  localparam int EWidth        = SinkWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_i,

  input  logic                             host_a_valid,
  output logic                             host_a_ready,
  input  logic [AWidth-1:0]                host_a,
  output logic                             host_b_valid,
  input  logic                             host_b_ready,
  output logic [AWidth-1:0]                host_b,
  input  logic                             host_c_valid,
  output logic                             host_c_ready,
  input  logic [CWidth-1:0]                host_c,
  output logic                             host_d_valid,
  input  logic                             host_d_ready,
  output logic [DWidth-1:0]                host_d,
  input  logic                             host_e_valid,
  output logic                             host_e_ready,
  input  logic [EWidth-1:0]                host_e,

  output logic [NumLinks-1:0]              device_a_valid,
  input  logic [NumLinks-1:0]              device_a_ready,
  output logic [NumLinks-1:0][AWidth-1:0]  device_a,
  input  logic [NumLinks-1:0]              device_b_valid,
  output logic [NumLinks-1:0]              device_b_ready,
  input  logic [NumLinks-1:0][AWidth-1:0]  device_b,
  output logic [NumLinks-1:0]              device_c_valid,
  input  logic [NumLinks-1:0]              device_c_ready,
  output logic [NumLinks-1:0][CWidth-1:0]  device_c,
  input  logic [NumLinks-1:0]              device_d_valid,
  output logic [NumLinks-1:0]              device_d_ready,
  input  logic [NumLinks-1:0][DWidth-1:0]  device_d,
  output logic [NumLinks-1:0]              device_e_valid,
  input  logic [NumLinks-1:0]              device_e_ready,
  output logic [NumLinks-1:0][EWidth-1:0]  device_e
);

  localparam int AAddrLsb = DataWidth + 1 + MaskWidth;
  localparam int CAddrLsb = DataWidth + 1;
  localparam int BArbN    = (NumCachedLinks > 0) ? NumCachedLinks : 1;

  // Unmatched addresses land on link 0; later table entries override earlier.
  function automatic logic [LinkWidth-1:0] addr_decode(logic [AddrWidth-1:0] addr);
    logic [LinkWidth-1:0] tgt;
    tgt = '0;
    for (int i = 0; i < NumAddrRange; i++) begin
      if (tl_range_match(TlMatchWidth'(addr), TlMatchWidth'(AddrBase[i]),
                         TlMatchWidth'(AddrMask[i]))) begin
        tgt = AddrLink[i];
      end
    end
    return tgt;
  endfunction

  function automatic logic [LinkWidth-1:0] sink_decode(logic [SinkWidth-1:0] sink);
    logic [LinkWidth-1:0] tgt;
    tgt = '0;
    for (int i = 0; i < NumSinkRange; i++) begin
      if (tl_range_match(TlMatchWidth'(sink), TlMatchWidth'(SinkBase[i]),
                         TlMatchWidth'(SinkMask[i]))) begin
        tgt = SinkLink[i];
      end
    end
    return tgt;
  endfunction

  logic [LinkWidth-1:0] a_tgt;
  logic [LinkWidth-1:0] c_raw;
  logic [LinkWidth-1:0] c_tgt;
  logic [LinkWidth-1:0] e_raw;
  logic [LinkWidth-1:0] e_tgt;

  assign a_tgt = addr_decode(host_a[AAddrLsb +: AddrWidth]);
  assign c_raw = addr_decode(host_c[CAddrLsb +: AddrWidth]);
  assign e_raw = sink_decode(host_e);
  // A C/E target outside the cached links is a table error; fall back to link 0.
  assign c_tgt = (int'(c_raw) < NumCachedLinks) ? c_raw : '0;
  assign e_tgt = (int'(e_raw) < NumCachedLinks) ? e_raw : '0;

  assign device_a = {NumLinks{host_a}};
  assign device_c = {NumLinks{host_c}};
  assign device_e = {NumLinks{host_e}};

  // A fan-out: only the decoded link sees valid, and its ready returns.
  always_comb begin
    host_a_ready   = 1'b0;
    device_a_valid = '0;
    for (int i = 0; i < NumLinks; i++) begin
      if (a_tgt == LinkWidth'(i)) begin
        device_a_valid[i] = host_a_valid;
        host_a_ready      = device_a_ready[i];
      end
    end
  end

  // C and E fan-out over cached links; with none cached the host is never stalled.
  always_comb begin
    host_c_ready   = (NumCachedLinks == 0);
    host_e_ready   = (NumCachedLinks == 0);
    device_c_valid = '0;
    device_e_valid = '0;
    for (int i = 0; i < NumCachedLinks; i++) begin
      if (c_tgt == LinkWidth'(i)) begin
        device_c_valid[i] = host_c_valid;
        host_c_ready      = device_c_ready[i];
      end
      if (e_tgt == LinkWidth'(i)) begin
        device_e_valid[i] = host_e_valid;
        host_e_ready      = device_e_ready[i];
      end
    end
  end

  logic [BArbN-1:0] b_gnt;

  if (NumCachedLinks > 0) begin : g_b
    openip_round_robin_arbiter #(.N(NumCachedLinks)) u_b_arb (
      .clk     (clk_i),
      .rst     (rst_i),
      .req     (device_b_valid[NumCachedLinks-1:0]),
      .advance (host_b_valid & host_b_ready),
      .gnt     (b_gnt)
    );

    // B merge: single-beat probes, so the live grant is used directly.
    always_comb begin
      host_b_valid = 1'b0;
      host_b       = '0;
      for (int i = 0; i < NumCachedLinks; i++) begin
        if (b_gnt[i]) begin
          host_b_valid = device_b_valid[i];
          host_b       = device_b[i];
        end
      end
    end
  end else begin : g_no_b
    assign b_gnt        = '0;
    assign host_b_valid = 1'b0;
    assign host_b       = '0;
  end

  // Non-cached links never probe; keep their B ready high so they cannot wedge.
  always_comb begin
    device_b_ready = '1;
    for (int i = 0; i < NumCachedLinks; i++) begin
      device_b_ready[i] = b_gnt[i] & host_b_ready;
    end
  end

  if (NumCachedLinks < NumLinks) begin : g_noncached
    logic unused_noncached;
    assign unused_noncached = ^{device_b_valid[NumLinks-1:NumCachedLinks],
                                device_b[NumLinks-1:NumCachedLinks],
                                device_c_ready[NumLinks-1:NumCachedLinks],
                                device_e_ready[NumLinks-1:NumCachedLinks]};
  end

  d_state_e              d_state;
  logic [NumLinks-1:0]   gnt_selected;
  logic                  gnt_locked;
  logic                  gnt_last;
  logic [NumLinks-1:0]   d_gnt;
  logic [NumLinks-1:0]   d_sel;

  assign gnt_locked = (d_state == D_LOCKED);
  assign d_sel      = gnt_locked ? gnt_selected : d_gnt;

  openip_round_robin_arbiter #(.N(NumLinks)) u_d_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (device_d_valid),
    .advance (host_d_valid & host_d_ready & ~gnt_locked),
    .gnt     (d_gnt)
  );

  tl_burst_tracker #(
    .DataWidth (DataWidth),
    .MaxSize   (MaxSize),
    .SizeWidth (SizeWidth)
  ) u_d_track (
    .clk    (clk_i),
    .rst    (rst_i),
    .valid  (host_d_valid),
    .ready  (host_d_ready),
    .opcode (host_d[DWidth-1 -: 3]),
    .size   (host_d[DWidth-6 -: SizeWidth]),
    .last   (gnt_last)
  );

  // D merge: a locked source that drops valid stalls the host rather than yielding.
  always_comb begin
    host_d_valid = 1'b0;
    host_d       = '0;
    for (int i = 0; i < NumLinks; i++) begin
      if (d_sel[i]) begin
        host_d_valid = device_d_valid[i];
        host_d       = device_d[i];
      end
    end
  end

  assign device_d_ready = d_sel & {NumLinks{host_d_ready}};

  // Lock on the first accepted beat; the last beat always reopens, so single beats never lock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_state      <= D_OPEN;
      gnt_selected <= '0;
    end else if (host_d_valid && host_d_ready) begin
      if (gnt_last) begin
        d_state <= D_OPEN;
      end else if (d_state == D_OPEN) begin
        d_state      <= D_LOCKED;
        gnt_selected <= d_gnt;
      end
    end
  end

endmodule
